mdc_output_reorder: RTL and testbench
=====================================

MDC_OUTPUT_REORDER -- requirements
Module: mdc_output_reorder

Interface
REQ-001 Parameter WIDTH, default 9, SHALL set the two's-complement width of each real/imaginary sample.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  a two-lane beat from the last MDC stage is present.
REQ-005 in_ready  output  1  block accepts the beat this cycle.
REQ-006 inUp_re, inUp_im  input  WIDTH each  upper-lane sample, signed.
REQ-007 inLow_re, inLow_im  input  WIDTH each  lower-lane sample, signed.
REQ-008 out_valid  output  1  serial natural-order sample present.
REQ-009 out_ready  input  1  downstream accepts the sample this cycle.
REQ-010 out_re, out_im  output  WIDTH each  serial sample, signed.
REQ-011 out_index  output  5  frequency bin index of the current output sample.
REQ-012 out_last  output  1  current output is bin 31 of the frame.

Function
REQ-013 Frame = 32 complex bins, delivered as 16 accepted input beats k = 0..15.
REQ-014 Beat k: upper lane SHALL be bin bitrev5(k), lower lane bin bitrev5(k)+1 (bitrev5 = 5-bit bit reversal).
REQ-015 Storage: two banks (ping-pong) of 32 complex entries each; no arithmetic, data stored and emitted bit-exact.
REQ-016 Each bank SHALL have state EMPTY, FILLING or FULL; write bank pointer wb and read bank pointer rb are 1 bit each.
REQ-017 in_ready SHALL be 1 iff bank[wb] is EMPTY or FILLING, decoded from registered state only.
REQ-018 On in_valid && in_ready: write upper to bank[wb][bitrev5(wcnt)], lower to bank[wb][bitrev5(wcnt)+1]; wcnt increments; bank EMPTY -> FILLING.
REQ-019 On the accepted beat with wcnt = 15: wcnt wraps to 0, bank[wb] -> FULL, wb toggles.
REQ-020 in_valid while in_ready = 0 SHALL be ignored (no write, no counter change); upstream must hold the beat.
REQ-021 out_valid SHALL be 1 iff bank[rb] is FULL; out_re/out_im SHALL equal bank[rb][rcnt]; out_index = rcnt; out_last = out_valid && rcnt == 31.
REQ-022 out_valid SHALL rise on the rising edge that accepts beat 15, so the first output is visible 1 cycle after the last input beat.
REQ-023 On out_valid && out_ready: rcnt increments; with rcnt = 31, rcnt wraps to 0, bank[rb] -> EMPTY, rb toggles.
REQ-024 While out_valid && !out_ready, out_re, out_im, out_index and out_last SHALL hold stable.
REQ-025 Bank freed by REQ-023 SHALL make in_ready = 1 from the next cycle, never combinationally in the same cycle.
REQ-026 A write to bank[wb] and a read from bank[rb] in the same cycle SHALL both complete; wb == rb only when both banks are in the same state.
REQ-027 Sustained throughput: with out_ready held 1, one frame per 32 cycles; input stalls (in_ready = 0) whenever both banks hold undrained data.

Reset
REQ-028 rst_n = 0 SHALL immediately force both banks EMPTY, wb = rb = 0, wcnt = rcnt = 0, in_ready = 1, out_valid = 0, out_last = 0, out_index = 0, out_re = out_im = 0.
REQ-029 Reset mid-frame SHALL discard partial and full frames; after release, the first accepted beat is beat 0 of a new frame.
REQ-030 Bank data contents need not be cleared; outputs SHALL nonetheless read 0 while out_valid = 0.

Verification
REQ-031 Single frame with inUp_re = bitrev5(k), inLow_re = bitrev5(k)+1, im = -re, out_ready = 1 -> 32 outputs, out_re = 0..31, out_im = 0..-31, out_index equals out_re, out_last only at index 31.
REQ-032 Back-to-back frames, in_valid always 1, out_ready = 1 -> frame 1 accepted in 16 cycles, frame 2 accepted in 16 cycles, then in_ready = 0 until frame 1 fully drains; frames emerge in order without gaps.
REQ-033 out_ready toggled 1/0 every cycle -> each sample held while stalled; 64 cycles per frame; no sample lost or duplicated.
REQ-034 rst_n pulsed low after 7 beats of a frame -> out_valid = 0 at once; the next 16 beats form a clean frame with out_re = 0..31.
REQ-035 Extreme values: all inputs = -256 / +255 with WIDTH = 9 -> output equals input bit-exact, no sign change.
REQ-036 in_valid asserted with in_ready = 0 (both banks FULL) -> no bank contents change; the held beat is accepted on the first cycle in_ready returns to 1.

Source files
------------

// File: rtl/mdc_output_reorder.sv
// Ping-pong reorder buffer: turns the two-lane, bit-reversed beats of the last
// MDC stage into a serial, natural-order stream of 32 bins per frame.
module mdc_output_reorder #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inUp_re,
  input  logic [WIDTH-1:0] inUp_im,
  input  logic [WIDTH-1:0] inLow_re,
  input  logic [WIDTH-1:0] inLow_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [4:0]       out_index,
  output logic             out_last
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Beat k's upper bin bitrev5(k) is always even (k < 16), its lower bin is the
  // odd neighbour; so even/odd bins live in separate single-write arrays whose
  // row is the 4-bit reversal of k.
  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  bank_state_t          bank_state_r [2];
  logic                 wb_r;
  logic                 rb_r;
  logic [3:0]           wcnt_r;
  logic [4:0]           rcnt_r;
  logic [2*WIDTH-1:0]   even_mem_r [32];
  logic [2*WIDTH-1:0]   odd_mem_r  [32];

  logic                 wr_fire_s;
  logic                 rd_fire_s;
  logic [4:0]           wr_addr_s;
  logic [4:0]           rd_addr_s;
  logic [2*WIDTH-1:0]   rd_word_s;

  // Handshake decode, from registered bank state only.
  always_comb begin
    in_ready  = (bank_state_r[wb_r] != BANK_FULL);
    out_valid = (bank_state_r[rb_r] == BANK_FULL);
    wr_fire_s = in_valid && in_ready;
    rd_fire_s = out_valid && out_ready;
    wr_addr_s = {wb_r, bitrev4(wcnt_r)};
    rd_addr_s = {rb_r, rcnt_r[4:1]};
  end

  // Bank state machine, pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state_r[0] <= BANK_EMPTY;
      bank_state_r[1] <= BANK_EMPTY;
      wb_r            <= 1'b0;
      rb_r            <= 1'b0;
      wcnt_r          <= 4'd0;
      rcnt_r          <= 5'd0;
    end else begin
      // A write and a read never target the same bank: that would need one bank
      // to be FULL and not FULL at once.
      if (wr_fire_s) begin
        wcnt_r <= wcnt_r + 4'd1;
        if (wcnt_r == 4'd15) begin
          bank_state_r[wb_r] <= BANK_FULL;
          wb_r               <= ~wb_r;
        end else begin
          bank_state_r[wb_r] <= BANK_FILLING;
        end
      end
      if (rd_fire_s) begin
        rcnt_r <= rcnt_r + 5'd1;
        if (rcnt_r == 5'd31) begin
          bank_state_r[rb_r] <= BANK_EMPTY;
          rb_r               <= ~rb_r;
        end
      end
    end
  end

  // Sample storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      even_mem_r[wr_addr_s] <= {inUp_re, inUp_im};
      odd_mem_r[wr_addr_s]  <= {inLow_re, inLow_im};
    end
  end

  // Output mux; data is forced to zero whenever no frame is being presented.
  always_comb begin
    if (rcnt_r[0]) begin
      rd_word_s = odd_mem_r[rd_addr_s];
    end else begin
      rd_word_s = even_mem_r[rd_addr_s];
    end
    out_index = rcnt_r;
    if (out_valid) begin
      out_re   = rd_word_s[2*WIDTH-1:WIDTH];
      out_im   = rd_word_s[WIDTH-1:0];
      out_last = (rcnt_r == 5'd31);
    end else begin
      out_re   = {WIDTH{1'b0}};
      out_im   = {WIDTH{1'b0}};
      out_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_mdc_output_reorder.sv
// Randomized bench for mdc_output_reorder against a frame-queue reference model.
module tb_mdc_output_reorder;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] up_re = '0, up_im = '0, low_re = '0, low_im = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_re, out_im;
  logic [4:0]   out_index;
  logic         out_last;

  mdc_output_reorder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .inUp_re(up_re), .inUp_im(up_im), .inLow_re(low_re), .inLow_im(low_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]   idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } smp_t;

  // Reference: finished frames waiting to be read out, in natural order.
  smp_t         exp_q[$];
  logic [W-1:0] part_re [32];
  logic [W-1:0] part_im [32];
  int           wcnt_m = 0;
  int           mode = 0;
  int           n_chk = 0;
  int           n_err = 0;
  logic         exp_rdy, exp_vld;

  function automatic int brev(input int k);
    logic [31:0] kv;
    int r;
    kv = k;
    r = 0;
    for (int i = 0; i < 5; i++) r = r | (int'(kv[4-i]) << i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Present a new beat (held until the model sees it accepted).
  task automatic new_beat();
    int b;
    b = brev(wcnt_m);
    case (mode)
      0: begin
        up_re  = W'(b);       up_im  = W'(-b);
        low_re = W'(b + 1);   low_im = W'(-(b + 1));
      end
      1: begin
        up_re  = W'($urandom); up_im  = W'($urandom);
        low_re = W'($urandom); low_im = W'($urandom);
      end
      default: begin
        up_re  = $urandom_range(1) ? 9'h100 : 9'h0FF;
        up_im  = $urandom_range(1) ? 9'h100 : 9'h0FF;
        low_re = $urandom_range(1) ? 9'h100 : 9'h0FF;
        low_im = $urandom_range(1) ? 9'h100 : 9'h0FF;
      end
    endcase
  endtask

  task automatic step();
    smp_t f;
    logic accepted;
    @(negedge clk);
    exp_rdy = (exp_q.size() <= 32);
    exp_vld = (exp_q.size() > 0);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
    if (exp_vld) begin
      f = exp_q[0];
      check("out_re", {23'd0, out_re}, {23'd0, f.re});
      check("out_im", {23'd0, out_im}, {23'd0, f.im});
      check("out_index", {27'd0, out_index}, {27'd0, f.idx});
      check("out_last", {31'd0, out_last}, {31'd0, (f.idx == 5'd31)});
    end else begin
      check("idle_re", {23'd0, out_re}, 32'd0);
      check("idle_im", {23'd0, out_im}, 32'd0);
      check("idle_last", {31'd0, out_last}, 32'd0);
    end
    @(posedge clk);
    accepted = in_valid && exp_rdy;
    if (exp_vld && out_ready) void'(exp_q.pop_front());
    if (accepted) begin
      part_re[brev(wcnt_m)]     = up_re;
      part_im[brev(wcnt_m)]     = up_im;
      part_re[brev(wcnt_m) + 1] = low_re;
      part_im[brev(wcnt_m) + 1] = low_im;
      wcnt_m++;
      if (wcnt_m == 16) begin
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), part_re[i], part_im[i]});
        wcnt_m = 0;
      end
    end
    #1;
    if (accepted) new_beat();
  endtask

  // rdy_mode: 0 always ready, 1 toggle, 2 never, 3 random
  task automatic run(input int cycles, input int vld_pct, input int rdy_mode);
    for (int c = 0; c < cycles; c++) begin
      in_valid = ($urandom_range(99) < vld_pct);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = c[0] ? 1'b0 : 1'b1;
        2: out_ready = 1'b0;
        default: out_ready = $urandom_range(1) ? 1'b1 : 1'b0;
      endcase
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_re", {23'd0, out_re}, 32'd0);
    check("rst_out_im", {23'd0, out_im}, 32'd0);
    check("rst_out_index", {27'd0, out_index}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    exp_q.delete();
    wcnt_m = 0;
    new_beat();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    // Single frame, natural-order ramp 0..31 with im = -re.
    mode = 0;
    run(16, 100, 0);
    run(40, 0, 0);
    // Back-to-back frames, input stalls once both banks hold data.
    run(80, 100, 0);
    run(40, 0, 0);
    // Downstream ready toggling every cycle.
    run(100, 100, 1);
    run(80, 0, 1);
    // Both banks full with a held beat, then release.
    run(40, 100, 2);
    run(80, 100, 0);
    run(40, 0, 0);
    // Reset after 7 beats, then a clean frame.
    run(7, 100, 0);
    do_reset();
    run(16, 100, 0);
    run(40, 0, 0);
    // Extreme values.
    mode = 2;
    new_beat();
    run(120, 100, 3);
    run(80, 0, 0);
    // Random traffic.
    mode = 1;
    new_beat();
    run(3000, 70, 3);
    run(100, 0, 0);
    check("drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
